// File: rtl/inst_fetch_if.sv
// Fetch-request and instruction-memory handshake bundle for inst_fetch.
// The slave modport is the fetch unit; the master modport is the core/memory side.
interface inst_fetch_if;
    logic        fetch_req;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic [1:0]  fetch_err;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  fetch_req, pc, flush, mem_ack, mem_rdata,
        output inst, inst_valid, fetch_err, busy, mem_req, mem_addr
    );

    modport master (
        output fetch_req, pc, flush, mem_ack, mem_rdata,
        input  inst, inst_valid, fetch_err, busy, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: serves PC requests from a one-entry last-PC buffer or
// instruction memory, flags misaligned PCs and aborts memory requests on timeout.
module inst_fetch #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.slave  bus
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned ERR_W   = 2;

    localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_MISALGN = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t               state_q,      state_d;
    logic [31:0]          inst_q,       inst_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [ERR_W-1:0]     fetch_err_q,  fetch_err_d;
    logic                 busy_q,       busy_d;
    logic                 mem_req_q,    mem_req_d;
    logic [31:0]          mem_addr_q,   mem_addr_d;
    logic [TIMER_W-1:0]   timer_q,      timer_d;
    logic                 nocache_q,    nocache_d;
    logic [31:0]          last_pc_q,    last_pc_d;
    logic [31:0]          buf_data_q,   buf_data_d;
    logic                 buf_vld_q,    buf_vld_d;

    logic                 buf_hit_c;
    logic                 timer_last_c;

    assign buf_hit_c    = buf_vld_q && (bus.pc == last_pc_q) && !bus.flush;
    assign timer_last_c = (timer_q == TIMER_W'(TIMEOUT - 1));

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        fetch_err_d  = fetch_err_q;
        busy_d       = busy_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        timer_d      = timer_q;
        nocache_d    = nocache_q;
        last_pc_d    = last_pc_q;
        buf_data_d   = buf_data_q;
        buf_vld_d    = buf_vld_q;

        case (state_q)
            S_IDLE: begin
                if (bus.fetch_req) begin
                    if (bus.pc[1:0] != 2'b00) begin
                        inst_d       = NOP;
                        fetch_err_d  = ERR_MISALGN;
                        inst_valid_d = 1'b1;
                    end else if (buf_hit_c) begin
                        inst_d       = buf_data_q;
                        fetch_err_d  = ERR_OK;
                        inst_valid_d = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.pc[31:2], 2'b00};
                        timer_d    = '0;
                        nocache_d  = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (bus.mem_ack) begin
                    inst_d       = bus.mem_rdata;
                    fetch_err_d  = ERR_OK;
                    inst_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                    if (!nocache_q) begin
                        last_pc_d  = mem_addr_q;
                        buf_data_d = bus.mem_rdata;
                        buf_vld_d  = 1'b1;
                    end
                end else if (timer_last_c) begin
                    inst_d       = NOP;
                    fetch_err_d  = ERR_TIMEOUT;
                    inst_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // Flush wins over a same-cycle fill and keeps an in-flight fill out of the buffer
        if (bus.flush) begin
            buf_vld_d = 1'b0;
            if (state_q == S_WAIT) begin
                nocache_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= ERR_OK;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            timer_q      <= '0;
            nocache_q    <= 1'b0;
            last_pc_q    <= '0;
            buf_data_q   <= '0;
            buf_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            timer_q      <= timer_d;
            nocache_q    <= nocache_d;
            last_pc_q    <= last_pc_d;
            buf_data_q   <= buf_data_d;
            buf_vld_q    <= buf_vld_d;
        end
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.busy       = busy_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: miss, hit, flush, misalignment, timeout and reset paths.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    inst_fetch_if bus ();

    inst_fetch #(
        .TIMEOUT (4),
        .NOP     (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.fetch_req = 1'b0;
        bus.pc        = 32'h0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_inst",     bus.inst,              NOP);
        chk("rst_valid",    32'(bus.inst_valid),   32'd0);
        chk("rst_err",      32'(bus.fetch_err),    32'd0);
        chk("rst_mem_req",  32'(bus.mem_req),      32'd0);
        chk("rst_mem_addr", bus.mem_addr,          32'h0);
        chk("rst_busy",     32'(bus.busy),         32'd0);
        rst = 1'b0;
        tick();

        // Miss to 0x100, zero-wait memory
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h100;
        tick();
        chk("miss_mem_req",  32'(bus.mem_req),    32'd1);
        chk("miss_mem_addr", bus.mem_addr,        32'h100);
        chk("miss_busy",     32'(bus.busy),       32'd1);
        chk("miss_valid0",   32'(bus.inst_valid), 32'd0);
        bus.fetch_req = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        tick();
        chk("miss_valid",    32'(bus.inst_valid), 32'd1);
        chk("miss_inst",     bus.inst,            32'h0050_0093);
        chk("miss_err",      32'(bus.fetch_err),  32'd0);
        chk("miss_req_drop", 32'(bus.mem_req),    32'd0);
        chk("miss_busy_drop",32'(bus.busy),       32'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        chk("miss_strobe_end", 32'(bus.inst_valid), 32'd0);
        chk("miss_inst_held",  bus.inst,            32'h0050_0093);

        // Hit on 0x100, then a back-to-back second hit
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h100;
        tick();
        chk("hit_valid",   32'(bus.inst_valid), 32'd1);
        chk("hit_inst",    bus.inst,            32'h0050_0093);
        chk("hit_mem_req", 32'(bus.mem_req),    32'd0);
        tick();
        chk("b2b_valid",   32'(bus.inst_valid), 32'd1);
        chk("b2b_mem_req", 32'(bus.mem_req),    32'd0);
        bus.fetch_req = 1'b0;
        tick();
        chk("hit_strobe_end", 32'(bus.inst_valid), 32'd0);

        // Flush with request forces a miss
        bus.fetch_req = 1'b1;
        bus.flush     = 1'b1;
        tick();
        chk("flush_miss_req", 32'(bus.mem_req),    32'd1);
        chk("flush_no_valid", 32'(bus.inst_valid), 32'd0);
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        tick();
        chk("flush_fill_valid", 32'(bus.inst_valid), 32'd1);
        bus.mem_ack = 1'b0;
        tick();

        // Misaligned PC
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h102;
        tick();
        chk("mis_valid",   32'(bus.inst_valid), 32'd1);
        chk("mis_inst",    bus.inst,            NOP);
        chk("mis_err",     32'(bus.fetch_err),  32'd1);
        chk("mis_mem_req", 32'(bus.mem_req),    32'd0);
        bus.fetch_req = 1'b0;
        tick();

        // Timeout: no ack, mem_req high exactly 4 cycles
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h400;
        tick();
        chk("to_req_c1", 32'(bus.mem_req), 32'd1);
        bus.fetch_req = 1'b0;
        tick();
        chk("to_req_c2", 32'(bus.mem_req), 32'd1);
        tick();
        chk("to_req_c3", 32'(bus.mem_req), 32'd1);
        tick();
        chk("to_req_c4", 32'(bus.mem_req), 32'd1);
        tick();
        chk("to_req_drop", 32'(bus.mem_req),    32'd0);
        chk("to_valid",    32'(bus.inst_valid), 32'd1);
        chk("to_inst",     bus.inst,            NOP);
        chk("to_err",      32'(bus.fetch_err),  32'd2);
        chk("to_busy",     32'(bus.busy),       32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("stray_valid", 32'(bus.inst_valid), 32'd0);
        chk("stray_inst",  bus.inst,            NOP);
        chk("stray_err",   32'(bus.fetch_err),  32'd2);
        chk("stray_req",   32'(bus.mem_req),    32'd0);
        bus.mem_ack = 1'b0;
        tick();

        // Ack in the last permitted cycle wins over the abort
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h500;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();
        tick();
        chk("late_req_held", 32'(bus.mem_req), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00A0_0113;
        tick();
        chk("late_valid", 32'(bus.inst_valid), 32'd1);
        chk("late_inst",  bus.inst,            32'h00A0_0113);
        chk("late_err",   32'(bus.fetch_err),  32'd0);
        bus.mem_ack = 1'b0;
        tick();

        // Miss to 0x200, flush in 2nd WAIT cycle, request to 0x300 ignored while busy
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h200;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        bus.flush     = 1'b1;
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h300;
        tick();
        chk("busy_ignore_busy", 32'(bus.busy), 32'd1);
        chk("busy_ignore_addr", bus.mem_addr,  32'h200);
        bus.flush     = 1'b0;
        bus.fetch_req = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0020_8233;
        tick();
        chk("nc_valid", 32'(bus.inst_valid), 32'd1);
        chk("nc_inst",  bus.inst,            32'h0020_8233);
        bus.mem_ack = 1'b0;
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h200;
        tick();
        chk("nc_rerequest_miss", 32'(bus.mem_req), 32'd1);
        chk("nc_rerequest_addr", bus.mem_addr,     32'h200);
        bus.fetch_req = 1'b0;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.fetch_req = 1'b1;
        tick();
        chk("fill_hit_valid", 32'(bus.inst_valid), 32'd1);
        chk("fill_hit_req",   32'(bus.mem_req),    32'd0);

        // Reset mid-WAIT
        bus.pc = 32'h600;
        tick();
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        bus.fetch_req = 1'b0;
        rst           = 1'b1;
        tick();
        chk("rst_wait_req",   32'(bus.mem_req),    32'd0);
        chk("rst_wait_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_wait_inst",  bus.inst,            NOP);
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        chk("rst_late_ack_valid", 32'(bus.inst_valid), 32'd0);
        bus.mem_ack   = 1'b0;
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h200;
        tick();
        chk("rst_buf_miss",  32'(bus.mem_req),    32'd1);
        chk("rst_buf_novld", 32'(bus.inst_valid), 32'd0);
        bus.fetch_req = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0020_8233;
        tick();
        chk("final_inst", bus.inst, 32'h0020_8233);
        bus.mem_ack = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
